dac_conversion: RTL and testbench

- Mirror of the ADC-side conversion path: takes an 8-bit display-domain value `numero` and converts it back to a 16-bit ADS1115-scale code.
- Mapping: code = numero*SCALE + OFFSET, saturated to the positive full scale. A raw mode instead places `numero` in bits [14:7].
- Samples the input once per sample period, computes the code with a sequential shift-add multiplier, and shifts it out MSB-first on a 3-wire SPI (mode 0) link to an external DAC.

---
 rtl/dac_conversion.sv | 149 ++++++++++++++
 tb/tb_dac_conversion.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_conversion.sv
// Converts an 8-bit display value to a 16-bit ADS1115-scale code once per sample period
// and shifts it MSB-first to an external DAC over SPI mode 0. Optional macro: DAC_LDAC_EN.
module dac_conversion #(
    parameter int PERIOD  = 5_000_000,
    parameter int SCALE   = 144,
    parameter int OFFSET  = 5000,
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        switch,
    input  logic [7:0]  numero,
    output logic [15:0] code,
    output logic        busy,
    output logic        done,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi
`ifdef DAC_LDAC_EN
    ,
    output logic        ldac_n
`endif
);

    localparam int CW = $clog2(PERIOD + 1);
    localparam int DW = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, CALC, SAT, SEND, FIN, LDAC, LFIN} state_t;

    state_t       state, nxt;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [7:0]    op;
    logic          mode;
    logic [23:0]   acc;
    logic [2:0]    it;
    logic [15:0]   shreg;
    logic [DW-1:0] div_cnt;
    logic          div_end;
    logic [4:0]    bit_cnt;
    logic          hi;
    logic [23:0]   addend;
    logic [23:0]   sum;
    logic [15:0]   new_code;

    assign tick    = (cnt == CW'(PERIOD - 1));
    assign div_end = (div_cnt == DW'(CLK_DIV - 1));
    assign addend  = 24'(SCALE) << it;
    assign sum     = acc + 24'(OFFSET);
    assign new_code = mode ? {1'b0, op, 7'b0}
                           : ((sum > 24'h007FFF) ? 16'h7FFF : sum[15:0]);

    // Free-running period counter; ticks while busy are simply lost.
    always_ff @(posedge clk) begin
        if (reset || tick) cnt <= '0;
        else               cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (tick) nxt = CALC;
            CALC: if (it == 3'd7) nxt = SAT;
            SAT:  nxt = SEND;
            SEND: if (bit_cnt == 5'd16 && div_end) nxt = FIN;
`ifdef DAC_LDAC_EN
            FIN:  nxt = LDAC;
            LDAC: if (div_end) nxt = LFIN;
            LFIN: nxt = IDLE;
`else
            FIN:  nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code    <= '0;
            op      <= '0;
            mode    <= 1'b0;
            acc     <= '0;
            it      <= '0;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            hi      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (tick) begin
                    op   <= numero;
                    mode <= switch;
                    acc  <= '0;
                    it   <= '0;
                end
                CALC: begin
                    if (op[it]) acc <= acc + addend;
                    it <= it + 1'b1;
                end
                SAT: begin
                    code    <= new_code;
                    shreg   <= new_code;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    hi      <= 1'b0;
                end
                SEND: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        // Shift on the falling edge so mosi is stable for the rising edge.
                        if (bit_cnt != 5'd16) begin
                            if (!hi) begin
                                hi <= 1'b1;
                            end else begin
                                hi      <= 1'b0;
                                bit_cnt <= bit_cnt + 1'b1;
                                shreg   <= {shreg[14:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                FIN:  div_cnt <= '0;
                LDAC: div_cnt <= div_end ? '0 : div_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
        cs_n = (state != SEND);
        sclk = (state == SEND) && hi;
        mosi = (state == SEND) && shreg[15];
`ifdef DAC_LDAC_EN
        done   = (state == LFIN);
        ldac_n = (state != LDAC);
`else
        done   = (state == FIN);
`endif
    end

endmodule

// File: tb/tb_dac_conversion.sv
// Randomized self-checking bench for dac_conversion: SPI frames decoded on sclk rising
// and compared against an arithmetic model of the code mapping and frame timing.
module tb_dac_conversion;

    localparam int P  = 100;
    localparam int D  = 2;
    localparam int P2 = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        switch = 1'b0;
    logic [7:0]  numero = 8'd0;
    logic [15:0] code, code2;
    logic        busy, done, cs_n, sclk, mosi;
    logic        busy2, done2, cs_n2, sclk2, mosi2;
`ifdef DAC_LDAC_EN
    logic        ldac_n, ldac_n2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_conversion #(.PERIOD(P), .SCALE(144), .OFFSET(5000), .CLK_DIV(D)) dut (
        .clk(clk), .reset(reset), .switch(switch), .numero(numero), .code(code),
        .busy(busy), .done(done), .cs_n(cs_n), .sclk(sclk), .mosi(mosi)
`ifdef DAC_LDAC_EN
        , .ldac_n(ldac_n)
`endif
    );

    dac_conversion #(.PERIOD(P2), .SCALE(144), .OFFSET(5000), .CLK_DIV(D)) dut2 (
        .clk(clk), .reset(reset), .switch(switch), .numero(numero), .code(code2),
        .busy(busy2), .done(done2), .cs_n(cs_n2), .sclk(sclk2), .mosi(mosi2)
`ifdef DAC_LDAC_EN
        , .ldac_n(ldac_n2)
`endif
    );

    // Reference: the mapping from the datasheet-level rules, plain integer arithmetic.
    function automatic logic [15:0] ref_code(input bit sw, input int n);
        int s;
        if (sw) return 16'(n * 128);
        s = n * 144 + 5000;
        return (s > 32767) ? 16'h7FFF : 16'(s);
    endfunction

    // Sample-period model and monitors
    int          cyc = 0;
    int          m = 0, m2 = 0;
    logic        p_sclk = 1'b0, p_csn = 1'b1, p_busy = 1'b0;
    logic [15:0] bits = '0, last_frame = '0;
    int          busy_cyc = 0, lat = 0, low_len = 0, frame_len = 0;
    int          done_cnt = 0, frame_cnt = 0;
    logic        tick_ok = 1'b0, done_al = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        m   <= reset ? 0 : ((m == P - 1) ? 0 : m + 1);
        m2  <= reset ? 0 : ((m2 == P2 - 1) ? 0 : m2 + 1);
    end

    always @(negedge clk) begin
        p_sclk <= sclk;
        p_csn  <= cs_n;
        p_busy <= busy;
        if (sclk && !p_sclk && !cs_n) bits <= {bits[14:0], mosi};
        if (busy && !p_busy) begin
            busy_cyc <= cyc;
            tick_ok  <= (m == 0);
        end
        if (!cs_n && p_csn) begin
            lat     <= cyc - busy_cyc;
            low_len <= 1;
        end else if (!cs_n) begin
            low_len <= low_len + 1;
        end
        if (cs_n && !p_csn) begin
            last_frame <= bits;
            frame_len  <= low_len;
            done_al    <= done;
            frame_cnt  <= frame_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // Drive inputs while idle, wait for the next serviced frame to complete.
    task automatic run_frame(input bit sw, input logic [7:0] n, input bit chg,
                             input logic [7:0] n2, output bit to);
        int base, k;
        to = 1'b0;
        @(negedge clk);
        for (k = 0; k < 4 * P && busy; k++) @(negedge clk);
        switch = sw;
        numero = n;
        base = done_cnt;
        for (k = 0; k < 4 * P && !busy; k++) @(negedge clk);
        if (!busy) to = 1'b1;
        if (chg) begin
            repeat (3) @(negedge clk);
            numero = n2;
        end
        for (k = 0; k < 400 && done_cnt == base; k++) @(negedge clk);
        if (done_cnt == base) to = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({code, busy, done, cs_n, sclk, mosi} !== {16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: code=%h busy=%b done=%b cs_n=%b sclk=%b mosi=%b, required 0000 0 0 1 0 0",
                     code, busy, done, cs_n, sclk, mosi);
        end
        reset = 1'b0;
    endtask

    task automatic test_frame(input string name, input bit sw, input logic [7:0] n,
                              input bit chg, input logic [7:0] n2, input logic [15:0] exp);
        bit to;
        int base;
        base = done_cnt;
        run_frame(sw, n, chg, n2, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s timeout: no complete frame seen", name);
        end
        checks++;
        if (code !== exp) begin
            errors++;
            $display("FAIL %s code: got %h, required %h", name, code, exp);
        end
        checks++;
        if (last_frame !== exp) begin
            errors++;
            $display("FAIL %s frame bits: got %h, required %h", name, last_frame, exp);
        end
        checks++;
        if (done_cnt !== base + 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d, required 1", name, done_cnt - base);
        end
        checks++;
        if ({lat, frame_len} !== {32'd9, 32'(33 * D)} || !tick_ok || !done_al) begin
            errors++;
            $display("FAIL %s timing: busy->cs_n %0d (req 9), cs_n low %0d (req %0d), tick_ok %b, done_at_cs_rise %b",
                     name, lat, frame_len, 33 * D, tick_ok, done_al);
        end
    endtask

    task automatic test_random;
        bit sw;
        logic [7:0] n;
        for (int i = 0; i < 6; i++) begin
            sw = 1'($urandom_range(0, 1));
            n  = 8'($urandom_range(0, 255));
            test_frame("random", sw, n, 1'b0, 8'h0, ref_code(sw, int'(n)));
        end
    endtask

    task automatic test_reset_mid_send;
        int k, base;
        @(negedge clk);
        switch = 1'b0;
        numero = 8'd77;
        for (k = 0; k < 4 * P && cs_n; k++) @(negedge clk);
        checks++;
        if (cs_n) begin
            errors++;
            $display("FAIL abort setup: cs_n never fell");
        end
        repeat (20) @(negedge clk);
        base = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cs_n, sclk, busy, done, code} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL abort: cs_n=%b sclk=%b busy=%b done=%b code=%h, required 1 0 0 0 0000",
                     cs_n, sclk, busy, done, code);
        end
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt !== base) begin
            errors++;
            $display("FAIL abort done: got %0d pulses, required 0", done_cnt - base);
        end
        test_frame("after_abort", 1'b0, 8'd77, 1'b0, 8'h0, ref_code(1'b0, 77));
    endtask

    task automatic test_drop;
        int ticks = 0, dones = 0, rises = 0, k;
        logic pb = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (k = 0; k < 3000 && (ticks < 20 || busy2); k++) begin
            @(negedge clk);
            if (m2 == 0 && ticks < 20) ticks++;
            if (done2) dones++;
            if (busy2 && !pb) rises++;
            pb = busy2;
        end
        checks++;
        if (ticks != 20 || busy2) begin
            errors++;
            $display("FAIL drop timeout: ticks %0d busy %b", ticks, busy2);
        end
        checks++;
        if (dones !== ticks / 2) begin
            errors++;
            $display("FAIL drop dones: got %0d, required %0d", dones, ticks / 2);
        end
        checks++;
        if (rises !== dones) begin
            errors++;
            $display("FAIL drop overlap: %0d frames started, %0d finished", rises, dones);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_frame("zero", 1'b0, 8'd0, 1'b0, 8'h0, 16'h1388);
        test_frame("n100", 1'b0, 8'd100, 1'b0, 8'h0, 16'h4BC8);
        test_frame("saturate", 1'b0, 8'd255, 1'b0, 8'h0, 16'h7FFF);
        test_frame("raw", 1'b1, 8'hA5, 1'b0, 8'h0, 16'h5280);
        test_frame("mid_change", 1'b0, 8'h10, 1'b1, 8'h20, 16'h1C88);
        test_reset_mid_send();
        test_random();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
